// File: rtl/uart_tx_param_if.sv
// Handshake and serial-line bundle for uart_tx_param.
// The master drives the request side; the slave (transmitter) drives ready, line and status.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_enable;
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data_in;
    logic                 tx_ready;
    logic                 tx_data_out;
    logic                 busy;
    logic                 done;

    modport master (
        output tx_enable, tx_start, tx_data_in,
        input  tx_ready, tx_data_out, busy, done
    );

    modport slave (
        input  tx_enable, tx_start, tx_data_in,
        output tx_ready, tx_data_out, busy, done
    );
endinterface

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, 5..9 data bits LSB first, optional parity, 1 or 2 stops.
// Define UART_TX_HOLD_EN to add a one-entry holding register for back-to-back frames.
module uart_tx_param #(
    parameter int CLOCK_RATE  = 10000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input logic            clk,
    input logic            rst,
    uart_tx_param_if.slave bus
);
    localparam int DIV   = (BAUD_RATE > 0) ? CLOCK_RATE / BAUD_RATE : 0;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD       = (PARITY_MODE == 2);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_tx_param: CLOCK_RATE/BAUD_RATE must be at least 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;

    logic                 accept;
    logic                 baud_last;
    logic                 stop_end;
    logic                 begin_frame;
    logic [DATA_BITS-1:0] frame_word;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign stop_end  = (state == STOP) && baud_last && (bit_cnt == STOP_LAST);
    assign accept    = bus.tx_start && bus.tx_ready;

`ifdef UART_TX_HOLD_EN
    logic                 hold_valid;
    logic [DATA_BITS-1:0] hold_data;

    // A held word wins at the end of a frame; otherwise a same-edge request starts directly.
    assign bus.tx_ready = bus.tx_enable && !hold_valid && !rst;
    assign frame_word   = hold_valid ? hold_data : bus.tx_data_in;
    assign begin_frame  = ((state == IDLE) && accept) || (stop_end && (hold_valid || accept));
`else
    assign bus.tx_ready = bus.tx_enable && (state == IDLE) && !rst;
    assign frame_word   = bus.tx_data_in;
    assign begin_frame  = (state == IDLE) && accept;
`endif

    // NOTE: only non-blocking assignments here, so every register samples pre-edge values
    // regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            baud_cnt        <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            par_bit         <= 1'b0;
            bus.tx_data_out <= 1'b1;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_valid      <= 1'b0;
            hold_data       <= '0;
`endif
        end else begin
            bus.done <= stop_end;

`ifdef UART_TX_HOLD_EN
            if (begin_frame) begin
                hold_valid <= 1'b0;
            end else if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= bus.tx_data_in;
            end
`endif

            if (state != IDLE) begin
                baud_cnt <= baud_last ? '0 : baud_cnt + 1'b1;
            end

            if (begin_frame) begin
                state           <= START;
                baud_cnt        <= '0;
                bit_cnt         <= '0;
                shift_reg       <= frame_word;
                par_bit         <= (^frame_word) ^ ODD;
                bus.tx_data_out <= 1'b0;
                bus.busy        <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    START: begin
                        if (baud_last) begin
                            state           <= DATA;
                            bus.tx_data_out <= shift_reg[0];
                            shift_reg       <= shift_reg >> 1;
                        end
                    end
                    DATA: begin
                        if (baud_last) begin
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                if (PARITY_MODE != 0) begin
                                    state           <= PARITY;
                                    bus.tx_data_out <= par_bit;
                                end else begin
                                    state           <= STOP;
                                    bus.tx_data_out <= 1'b1;
                                end
                            end else begin
                                bit_cnt         <= bit_cnt + 1'b1;
                                bus.tx_data_out <= shift_reg[0];
                                shift_reg       <= shift_reg >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (baud_last) begin
                            state           <= STOP;
                            bus.tx_data_out <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (baud_last) begin
                            if (bit_cnt == STOP_LAST) begin
                                state    <= IDLE;
                                bus.busy <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: four configurations share one clock and are compared
// every cycle against a frame-level model built from per-cycle line levels.
module tb_uart_tx_param;
    localparam int N = 4;

    localparam int CFG_DBITS [N] = '{8, 8, 8, 7};
    localparam int CFG_PAR   [N] = '{0, 1, 2, 1};
    localparam int CFG_STOP  [N] = '{1, 1, 2, 1};
    localparam int CFG_DIV   [N] = '{16, 16, 16, 5};

    localparam bit LIT_5A [10] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};

`ifdef UART_TX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_param_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_param_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_param_if #(.DATA_BITS(7)) bus3 ();

    uart_tx_param #(.CLOCK_RATE(153600), .BAUD_RATE(9600), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1)) u0 (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_param #(.CLOCK_RATE(153600), .BAUD_RATE(9600), .DATA_BITS(8),
                    .PARITY_MODE(1), .STOP_BITS(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx_param #(.CLOCK_RATE(153600), .BAUD_RATE(9600), .DATA_BITS(8),
                    .PARITY_MODE(2), .STOP_BITS(2)) u2 (.clk(clk), .rst(rst), .bus(bus2));
    uart_tx_param #(.CLOCK_RATE(48000), .BAUD_RATE(9600), .DATA_BITS(7),
                    .PARITY_MODE(1), .STOP_BITS(1)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    logic       in_rst;
    logic       in_en    [N];
    logic       in_start [N];
    logic [8:0] in_data  [N];

    logic obs_line  [N];
    logic obs_busy  [N];
    logic obs_done  [N];
    logic obs_ready [N];

    // Model: remaining line level of the frame in flight, one entry per clock cycle.
    bit         line_q    [N][$];
    bit         exp_done  [N];
    bit         hold_full [N];
    logic [8:0] hold_word [N];
    bit         ready_exp [N];
    bit         model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    task automatic check(input string name, input int d, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %b, expected %b", name, d, cycle, act, want);
        end
    endtask

    function automatic void push_frame(input int d, input logic [8:0] w);
        bit bits[$];
        bit p;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < CFG_DBITS[d]; i++) begin
            bits.push_back(w[i]);
            p ^= w[i];
        end
        if (CFG_PAR[d] != 0) bits.push_back((CFG_PAR[d] == 2) ? !p : p);
        for (int i = 0; i < CFG_STOP[d]; i++) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int r = 0; r < CFG_DIV[d]; r++) line_q[d].push_back(bits[k]);
        end
    endfunction

    // NOTE: stimulus uses blocking assignments at the falling edge, well clear of the
    // rising edge the DUT samples on.
    task automatic drive();
        rst             = in_rst;
        bus0.tx_enable  = in_en[0];
        bus0.tx_start   = in_start[0];
        bus0.tx_data_in = in_data[0][7:0];
        bus1.tx_enable  = in_en[1];
        bus1.tx_start   = in_start[1];
        bus1.tx_data_in = in_data[1][7:0];
        bus2.tx_enable  = in_en[2];
        bus2.tx_start   = in_start[2];
        bus2.tx_data_in = in_data[2][7:0];
        bus3.tx_enable  = in_en[3];
        bus3.tx_start   = in_start[3];
        bus3.tx_data_in = in_data[3][6:0];
    endtask

    task automatic sample_out();
        obs_line[0] = bus0.tx_data_out; obs_busy[0] = bus0.busy; obs_done[0] = bus0.done;
        obs_line[1] = bus1.tx_data_out; obs_busy[1] = bus1.busy; obs_done[1] = bus1.done;
        obs_line[2] = bus2.tx_data_out; obs_busy[2] = bus2.busy; obs_done[2] = bus2.done;
        obs_line[3] = bus3.tx_data_out; obs_busy[3] = bus3.busy; obs_done[3] = bus3.done;
    endtask

    task automatic sample_ready();
        obs_ready[0] = bus0.tx_ready;
        obs_ready[1] = bus1.tx_ready;
        obs_ready[2] = bus2.tx_ready;
        obs_ready[3] = bus3.tx_ready;
    endtask

    // One clock cycle: compare current outputs, apply the inputs for the next edge, advance model.
    task automatic step();
        bit acc;
        bit was_last;
        @(negedge clk);
        cycle++;
        sample_out();
        if (model_valid) begin
            for (int d = 0; d < N; d++) begin
                check("line", d, obs_line[d], (line_q[d].size() > 0) ? line_q[d][0] : 1'b1);
                check("busy", d, obs_busy[d], line_q[d].size() > 0);
                check("done", d, obs_done[d], exp_done[d]);
            end
        end
        drive();
        #1;
        sample_ready();
        for (int d = 0; d < N; d++) begin
            ready_exp[d] = !in_rst && in_en[d] && (HOLD ? !hold_full[d] : (line_q[d].size() == 0));
            check("ready", d, obs_ready[d], ready_exp[d]);
        end
        if (in_rst) begin
            model_valid = 1'b1;
            for (int d = 0; d < N; d++) begin
                line_q[d].delete();
                exp_done[d]  = 1'b0;
                hold_full[d] = 1'b0;
            end
        end else if (model_valid) begin
            for (int d = 0; d < N; d++) begin
                acc      = in_start[d] && ready_exp[d];
                was_last = (line_q[d].size() == 1);
                if (line_q[d].size() > 0) void'(line_q[d].pop_front());
                exp_done[d] = was_last;
                if (was_last && hold_full[d]) begin
                    push_frame(d, hold_word[d]);
                    hold_full[d] = 1'b0;
                end else if (acc && line_q[d].size() == 0) begin
                    push_frame(d, in_data[d]);
                end else if (acc) begin
                    hold_full[d] = 1'b1;
                    hold_word[d] = in_data[d];
                end
            end
        end
    endtask

    task automatic all_inputs(input logic en, input logic start);
        for (int d = 0; d < N; d++) begin
            in_en[d]    = en;
            in_start[d] = start;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        bit any_done;

        in_rst = 1'b1;
        all_inputs(1'b1, 1'b0);
        for (int d = 0; d < N; d++) in_data[d] = '0;
        step();
        check("rst_ready", 0, obs_ready[0], 1'b0);
        in_rst = 1'b0;
        all_inputs(1'b0, 1'b0);
        repeat (3) step();
        check("rst_line", 0, obs_line[0], 1'b1);
        check("rst_busy", 0, obs_busy[0], 1'b0);
        check("rst_done", 0, obs_done[0], 1'b0);

        // Same word on every configuration; u3 sends 0x7F with seven data bits.
        all_inputs(1'b1, 1'b1);
        in_data[0] = 9'h05A;
        in_data[1] = 9'h05A;
        in_data[2] = 9'h05A;
        in_data[3] = 9'h07F;
        step();
        all_inputs(1'b1, 1'b0);
        for (int i = 1; i <= 200; i++) begin
            step();
            if (i >= 8 && (i - 8) % 16 == 0 && (i - 8) / 16 < 10)
                check("u0_5a_bit", 0, obs_line[0], LIT_5A[(i - 8) / 16]);
            if (i == 160) check("u0_done_early", 0, obs_done[0], 1'b0);
            if (i == 161) begin
                check("u0_done_161", 0, obs_done[0], 1'b1);
                check("u0_idle_161", 0, obs_busy[0], 1'b0);
            end
            if (i == 152) begin
                check("even_parity_5a", 1, obs_line[1], 1'b0);
                check("odd_parity_5a", 2, obs_line[2], 1'b1);
            end
            if (i == 177) check("8e1_done_177", 1, obs_done[1], 1'b1);
            if (i == 170 || i == 185) check("two_stop_high", 2, obs_line[2], 1'b1);
            if (i == 193) check("8o2_done_193", 2, obs_done[2], 1'b1);
            if (i == 3) check("7e1_start", 3, obs_line[3], 1'b0);
            if (i >= 8 && i <= 38 && (i - 8) % 5 == 0) check("7e1_data_one", 3, obs_line[3], 1'b1);
            if (i == 43) check("7e1_parity", 3, obs_line[3], 1'b1);
            if (i == 51) check("7e1_done_51", 3, obs_done[3], 1'b1);
        end

        // Reset in the middle of a frame: line high, not busy, and no done afterwards.
        in_start[0] = 1'b1;
        in_data[0]  = 9'h0C3;
        step();
        in_start[0] = 1'b0;
        for (int i = 1; i < 50; i++) step();
        in_rst = 1'b1;
        step();
        in_rst = 1'b0;
        step();
        check("abort_line", 0, obs_line[0], 1'b1);
        check("abort_busy", 0, obs_busy[0], 1'b0);
        any_done = 1'b0;
        for (int i = 52; i <= 200; i++) begin
            step();
            any_done |= obs_done[0];
        end
        check("abort_no_done", 0, any_done, 1'b0);

        // Disabled: requests are ignored and the line stays idle.
        all_inputs(1'b0, 1'b1);
        for (int d = 0; d < N; d++) in_data[d] = 9'h0A5;
        repeat (20) begin
            step();
            check("disabled_ready", 0, obs_ready[0], 1'b0);
            check("disabled_line", 0, obs_line[0], 1'b1);
        end
        all_inputs(1'b1, 1'b0);
        step();

`ifdef UART_TX_HOLD_EN
        in_start[0] = 1'b1;
        in_data[0]  = 9'h011;
        step();
        in_start[0] = 1'b0;
        for (int i = 1; i <= 330; i++) begin
            if (i == 20) begin
                in_start[0] = 1'b1;
                in_data[0]  = 9'h022;
            end else begin
                in_start[0] = 1'b0;
            end
            step();
            if (i == 20) check("hold_ready_empty", 0, obs_ready[0], 1'b1);
            if (i == 30 || i == 100) check("hold_ready_full", 0, obs_ready[0], 1'b0);
            if (i == 160) check("hold_stop_bit", 0, obs_line[0], 1'b1);
            if (i == 161) begin
                check("hold_back_to_back_start", 0, obs_line[0], 1'b0);
                check("hold_done_pulse", 0, obs_done[0], 1'b1);
                check("hold_still_busy", 0, obs_busy[0], 1'b1);
            end
            if (i == 162) check("hold_ready_again", 0, obs_ready[0], 1'b1);
        end
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < N; d++) begin
                in_en[d]    = ($urandom_range(0, 9) != 0);
                in_start[d] = ($urandom_range(0, 3) == 0);
                in_data[d]  = 9'($urandom);
            end
            in_rst = ($urandom_range(0, 799) == 0);
            step();
        end
        in_rst = 1'b0;
        all_inputs(1'b1, 1'b0);
        repeat (250) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL use exactly one clock and one reset: one clock; reset is synchronous and active-high.
REQ-002 SHALL have parameter CLOCK_RATE, default 10000000, meaning the clk frequency in Hz.
REQ-003 SHALL have parameter BAUD_RATE, default 9600, meaning the line bit rate in bit/s.
REQ-004 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..9).
REQ-005 SHALL have parameter PARITY_MODE, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-006 SHALL have parameter STOP_BITS, default 1, meaning stop bits per frame (legal 1 or 2).
REQ-007 SHALL have port clk, input, 1 bit, system clock.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port tx_enable, input, 1 bit, permits new frames to start.
REQ-010 SHALL have port tx_start, input, 1 bit, data valid request.
REQ-011 SHALL have port tx_data_in, input, DATA_BITS bits, payload to send.
REQ-012 SHALL have port tx_ready, output, 1 bit, block can accept tx_data_in this cycle.
REQ-013 SHALL have port tx_data_out, output, 1 bit, registered serial line (idle high).
REQ-014 SHALL have port busy, output, 1 bit, frame in progress.
REQ-015 SHALL have port done, output, 1 bit, one-cycle end-of-frame pulse.

Function
REQ-016 SHALL derive DIV = CLOCK_RATE/BAUD_RATE (integer division) internally; DIV < 2 or an illegal parameter SHALL be a elaboration-time error; no external baud clock.
REQ-017 SHALL hold every line bit for exactly DIV clk cycles.
REQ-018 SHALL accept a word on a rising edge where tx_start && tx_ready; tx_data_in is captured on that edge and may change afterwards.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP; IDLE->START on accept; START->DATA after DIV cycles; DATA->PARITY (PARITY_MODE != 0) or ->STOP after DATA_BITS bits; PARITY->STOP after DIV cycles; STOP->IDLE after STOP_BITS*DIV cycles.
REQ-020 SHALL drive tx_data_out low starting the cycle after the accept edge (latency 1), data LSB first, parity, then high stop bit(s).
REQ-021 SHALL compute parity over the captured word: even mode bit = XOR of data bits, odd mode = its inverse.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL pulse done for exactly one cycle, the first cycle after the final stop bit period ends.
REQ-024 SHALL drive tx_ready = tx_enable && (state == IDLE) (without hold buffer); tx_start while tx_ready low SHALL be ignored.
REQ-025 SHALL let a frame in progress complete when tx_enable deasserts mid-frame.
REQ-026 SHALL start a frame accepted in the done cycle on the next edge, giving zero idle bits between frames.

Reset
REQ-027 SHALL, on a clk edge with rst high, set state IDLE, tx_data_out 1, busy 0, done 0, tx_ready 0, baud and bit counters 0, hold buffer empty.
REQ-028 SHALL abort any frame when rst asserts mid-frame; line returns high the next edge, no done pulse.

Configuration
REQ-029 SHALL, with macro UART_TX_HOLD_EN defined, add a one-entry holding register: tx_ready = tx_enable && hold empty; accepts during a frame; at end of stop period a full hold goes STOP->START directly (done still pulses that cycle).
REQ-030 SHALL, without UART_TX_HOLD_EN, have no holding register and behave per REQ-024.

Verification
REQ-031 SHALL cover: DIV=16, 8N1, accept 0x5A -> line 0 | 0,1,0,1,1,0,1,0 | 1, each bit 16 cycles, done at cycle 161 after accept.
REQ-032 SHALL cover: PARITY_MODE=1 then 2, 0x5A -> parity bit 0 then 1; frame 11 bits; STOP_BITS=2 -> stop high 32 cycles.
REQ-033 SHALL cover: DATA_BITS=7, 0x7F -> seven 1s after start, even parity bit 1.
REQ-034 SHALL cover: rst asserted at cycle 50 of frame -> tx_data_out 1, busy 0 next edge, no done; tx_enable low -> tx_start 1 ignored, line stays 1.
REQ-035 SHALL cover: UART_TX_HOLD_EN, 0x11 then 0x22 accepted during frame 1 -> frame 2 start bit begins immediately after frame 1 stop bit, tx_ready low while hold full.
